// File: rtl/bootrom_ahb_if.sv
// AHB-Lite read-only slave front end for the bootrom macro.
// Turns read address phases into the ROM's EN/W_ADDR request and answers writes with a two-cycle ERROR.
module bootrom_ahb_if #(
  parameter int AW_ADDR_W   = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic                 ROM_EN,
  output logic [AW_ADDR_W-1:0] ROM_ADDR,
  input  logic [31:0]          ROM_RDATA
);

  typedef enum logic [1:0] {IDLE, RD_DATA, ERR1, ERR2} state_t;

  localparam logic [1:0] WS_LOAD = 2'(WAIT_STATES);

  state_t      state;
  logic [1:0]  wcnt;
  logic [31:0] rdata_q;
  logic        hreadyout_q;
  logic        hresp_q;

  logic acc, rd_acc, wr_acc;
  logic can_accept;
  logic data_valid;
  logic unused_bits;

  assign acc    = HSEL & HTRANS[1] & HREADY;
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;

  // The macro samples EN/W_ADDR itself at the end of the address phase.
  assign ROM_EN   = rd_acc & ~RST;
  assign ROM_ADDR = HADDR[AW_ADDR_W+1:2];

  // A new transfer can only start in a cycle where this slave shows HREADYOUT=1.
  assign can_accept = (state == IDLE) || (state == ERR2) ||
                      ((state == RD_DATA) && (wcnt == 2'd0));
  assign data_valid = (state == RD_DATA) && (wcnt == 2'd0);

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = !data_valid       ? 32'h0 :
                     (WAIT_STATES == 0) ? ROM_RDATA : rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wcnt        <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else if (can_accept) begin
      if (rd_acc) begin
        state       <= RD_DATA;
        wcnt        <= WS_LOAD;
        hreadyout_q <= (WS_LOAD == 2'd0);
        hresp_q     <= 1'b0;
      end else if (wr_acc) begin
        state       <= ERR1;
        hreadyout_q <= 1'b0;
        hresp_q     <= 1'b1;
      end else begin
        state       <= IDLE;
        hreadyout_q <= 1'b1;
        hresp_q     <= 1'b0;
      end
    end else if (state == ERR1) begin
      state       <= ERR2;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b1;
    end else begin
      // Read wait cycle: ready rises together with the final data cycle.
      wcnt        <= wcnt - 2'd1;
      hreadyout_q <= (wcnt == 2'd1);
      hresp_q     <= 1'b0;
    end
  end

  // With wait states, ROM_RDATA is held here so the final data cycle is independent of the macro.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= 32'h0;
    end else if ((WAIT_STATES > 0) && (state == RD_DATA) && (wcnt == WS_LOAD)) begin
      rdata_q <= ROM_RDATA;
    end
  end

  assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:AW_ADDR_W+2], HADDR[1:0]};

endmodule

// File: tb/tb_bootrom_ahb_if.sv
// Self-checking bench for bootrom_ahb_if: three instances (0, 2 and 3 wait states),
// a transaction-level response model per instance, and directed reads/writes with literal checks.
module tb_bootrom_ahb_if;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } exp_t;

  localparam exp_t IDLE_EXP = '{rdy: 1'b1, resp: 1'b0, data: 32'h0};
  localparam int   NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic        hsel   [NI];
  logic [31:0] haddr  [NI];
  logic [1:0]  htrans [NI];
  logic        hwrite [NI];
  logic [2:0]  hsize  [NI];

  logic [31:0] hrdata    [NI];
  logic        hreadyout [NI];
  logic        hresp     [NI];
  logic        rom_en    [NI];
  logic [7:0]  rom_addr  [NI];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    logic [7:0] t;
    t = a * 8'd3;
    return {8'hA5, a, ~a, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar i = 0; i < NI; i++) begin : g
    localparam int WS = (i == 0) ? 0 : ((i == 1) ? 2 : 3);

    exp_t        q[$];
    exp_t        cur = IDLE_EXP;
    logic        hready_m;
    logic [31:0] rom_rdata = 32'h0;

    assign hready_m = cur.rdy;

    bootrom_ahb_if #(.AW_ADDR_W(8), .WAIT_STATES(WS)) dut (
      .CLK(clk), .RST(rst), .HSEL(hsel[i]), .HADDR(haddr[i]), .HTRANS(htrans[i]),
      .HWRITE(hwrite[i]), .HSIZE(hsize[i]), .HREADY(hready_m),
      .HRDATA(hrdata[i]), .HREADYOUT(hreadyout[i]), .HRESP(hresp[i]),
      .ROM_EN(rom_en[i]), .ROM_ADDR(rom_addr[i]), .ROM_RDATA(rom_rdata)
    );

    // Synchronous ROM macro: data appears the cycle after EN is sampled.
    always @(posedge clk) if (rom_en[i] === 1'b1) rom_rdata <= rom_word(rom_addr[i]);

    // Response model: an accepted transfer queues the exact sequence of data-phase cycles it owes.
    always @(posedge clk) begin
      exp_t nxt;
      if (rst) begin
        q.delete();
        nxt = IDLE_EXP;
      end else begin
        if (cur.rdy && hsel[i] && htrans[i][1]) begin
          if (hwrite[i]) begin
            q.push_back('{rdy: 1'b0, resp: 1'b1, data: 32'h0});
            q.push_back('{rdy: 1'b1, resp: 1'b1, data: 32'h0});
          end else begin
            for (int w = 0; w < WS; w++) q.push_back('{rdy: 1'b0, resp: 1'b0, data: 32'h0});
            q.push_back('{rdy: 1'b1, resp: 1'b0, data: rom_word(haddr[i][9:2])});
          end
        end
        nxt = (q.size() > 0) ? q.pop_front() : IDLE_EXP;
      end
      cur <= nxt;
    end

    always @(negedge clk) begin
      if (started) begin
        logic exp_en;
        exp_en = !rst && hsel[i] && htrans[i][1] && cur.rdy && !hwrite[i];
        check($sformatf("hreadyout[%0d]", i), 32'(hreadyout[i]), 32'(cur.rdy));
        check($sformatf("hresp[%0d]", i), 32'(hresp[i]), 32'(cur.resp));
        check($sformatf("hrdata[%0d]", i), hrdata[i], cur.data);
        check($sformatf("rom_en[%0d]", i), 32'(rom_en[i]), 32'(exp_en));
        if (exp_en) check($sformatf("rom_addr[%0d]", i), 32'(rom_addr[i]), 32'(haddr[i][9:2]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [2:0] sz);
    hsel[k]   = sel;
    htrans[k] = tr;
    hwrite[k] = wr;
    haddr[k]  = a;
    hsize[k]  = sz;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 2'b00, 1'b0, 32'h0, 3'b010);
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (hreadyout[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(hreadyout[k]), 32'h1);
  endtask

  // Single read; returns the final-cycle data and the number of cycles HREADYOUT was low.
  task automatic rd(input int k, input logic [31:0] a, input logic [2:0] sz,
                    output logic [31:0] d, output int nw);
    wait_ready(k);
    drive(k, 1'b1, 2'b10, 1'b0, a, sz);
    tick();
    idle(k);
    #1;
    nw = 0;
    while (hreadyout[k] !== 1'b1 && nw < 10) begin
      check("rd_wait_hrdata", hrdata[k], 32'h0);
      nw++;
      @(posedge clk);
      #2;
    end
    d = hrdata[k];
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int          nw;

    for (int k = 0; k < NI; k++) idle(k);
    // Reset with an idle transfer selected on instance 0 and a read attempt on instance 1.
    drive(0, 1'b1, 2'b00, 1'b0, 32'h10, 3'b010);
    drive(1, 1'b1, 2'b10, 1'b0, 32'h10, 3'b010);
    @(posedge clk);
    started = 1'b1;
    #1;
    check("rst_rom_en_read", 32'(rom_en[1]), 32'h0);
    tick();
    rst = 1'b0;
    idle(1);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_hreadyout", 32'(hreadyout[k]), 32'h1);
      check("rst_hresp", 32'(hresp[k]), 32'h0);
      check("rst_hrdata", hrdata[k], 32'h0);
      check("rst_rom_en", 32'(rom_en[k]), 32'h0);
    end
    repeat (3) tick();
    idle(0);

    // Zero wait states: single read of 0x10.
    drive(0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'b010);
    #1;
    check("ws0_rom_en", 32'(rom_en[0]), 32'h1);
    check("ws0_rom_addr", 32'(rom_addr[0]), 32'h04);
    tick();
    idle(0);
    #1;
    check("ws0_ready", 32'(hreadyout[0]), 32'h1);
    check("ws0_word4", hrdata[0], 32'hA504FB0C);
    tick();

    // Back-to-back reads of words 0..3.
    drive(0, 1'b1, 2'b10, 1'b0, 32'h0, 3'b010);
    tick();
    drive(0, 1'b1, 2'b10, 1'b0, 32'h4, 3'b010);
    #1;
    check("b2b_word0", hrdata[0], 32'hA500FF00);
    tick();
    drive(0, 1'b1, 2'b10, 1'b0, 32'h8, 3'b010);
    #1;
    check("b2b_word1", hrdata[0], 32'hA501FE03);
    tick();
    drive(0, 1'b1, 2'b10, 1'b0, 32'hC, 3'b010);
    #1;
    check("b2b_word2", hrdata[0], 32'hA502FD06);
    tick();
    idle(0);
    #1;
    check("b2b_word3", hrdata[0], 32'hA503FC09);
    tick();

    // Byte-sized read and an aliased upper address both hit word 4.
    rd(0, 32'h0000_0013, 3'b000, d, nw);
    check("byte_word4", d, 32'hA504FB0C);
    rd(0, 32'h1000_0010, 3'b010, d, nw);
    check("alias_word4", d, 32'hA504FB0C);

    // Two wait states: top word.
    wait_ready(1);
    drive(1, 1'b1, 2'b10, 1'b0, 32'h3FC, 3'b010);
    #1;
    check("ws2_rom_addr", 32'(rom_addr[1]), 32'hFF);
    tick();
    idle(1);
    rd(1, 32'h3FC, 3'b010, d, nw);
    check("ws2_nwait", 32'(nw), 32'd2);
    check("ws2_word255", d, 32'hA5FF00FD);

    // Write to 0x20 then a read of 0x24 issued during ERR2.
    wait_ready(0);
    drive(0, 1'b1, 2'b10, 1'b1, 32'h20, 3'b010);
    #1;
    check("wr_rom_en", 32'(rom_en[0]), 32'h0);
    tick();
    idle(0);
    #1;
    check("err1_ready", 32'(hreadyout[0]), 32'h0);
    check("err1_resp", 32'(hresp[0]), 32'h1);
    tick();
    drive(0, 1'b1, 2'b10, 1'b0, 32'h24, 3'b010);
    #1;
    check("err2_ready", 32'(hreadyout[0]), 32'h1);
    check("err2_resp", 32'(hresp[0]), 32'h1);
    check("err2_rd_rom_en", 32'(rom_en[0]), 32'h1);
    tick();
    idle(0);
    #1;
    check("after_err_resp", 32'(hresp[0]), 32'h0);
    check("after_err_word9", hrdata[0], 32'hA509F61B);
    tick();

    // Three wait states: reset in the second wait cycle abandons the read.
    wait_ready(2);
    drive(2, 1'b1, 2'b10, 1'b0, 32'h10, 3'b010);
    tick();
    idle(2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(hreadyout[2]), 32'h1);
    check("midrst_hrdata", hrdata[2], 32'h0);
    check("midrst_resp", 32'(hresp[2]), 32'h0);
    tick();
    rd(2, 32'h8, 3'b010, d, nw);
    check("ws3_nwait", 32'(nw), 32'd3);
    check("ws3_word2", d, 32'hA502FD06);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
